// File: rtl/param_register_file.sv
// Parameterised two-read/one-write register file that self-clears through an INIT sweep of NUM_REGS cycles.
// Read latency 1 cycle (a/b/rd_valid registered); ready low while INIT runs, reads and writes ignored then.
// Optional REGFILE_BYPASS_EN forwards same-edge write_data to matching read ports.
module param_register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 8,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] write_data,
    input  logic              init_req,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic              rd_valid,
    output logic              ready
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_ok;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return int'(addr) < NUM_REGS;
    endfunction

    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] v;
        v = '0;
        if (addr_ok(addr) && !is_zero(addr)) begin
            v = regs[addr[IDX_W-1:0]];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (write_reg == addr))
                v = write_data;
`endif
        end
        return v;
    endfunction

    // A write coinciding with init_req is dropped: the sweep starts on that edge.
    always_comb begin
        wr_ok = (state == RUN) && RegWrite && !init_req &&
                addr_ok(write_reg) && !is_zero(write_reg);
        rd_a  = read_port(rs);
        rd_b  = read_port(rt);
    end

    // Storage carries no reset; contents are cleared by the INIT sweep instead.
    always_ff @(posedge clk) begin
        if (state == INIT)
            regs[idx] <= '0;
        else if (wr_ok)
            regs[write_reg[IDX_W-1:0]] <= write_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= INIT;
            idx      <= '0;
            ready    <= 1'b0;
            rd_valid <= 1'b0;
            a        <= '0;
            b        <= '0;
        end else begin
            case (state)
                INIT: begin
                    rd_valid <= 1'b0;
                    if (int'(idx) == NUM_REGS - 1) begin
                        state <= RUN;
                        ready <= 1'b1;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                RUN: begin
                    rd_valid <= rd_en;
                    if (rd_en) begin
                        a <= rd_a;
                        b <= rd_b;
                    end
                    if (init_req) begin
                        state <= INIT;
                        ready <= 1'b0;
                        idx   <= '0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file (NUM_REGS=8, ZERO_REG=1); expectations follow REGFILE_BYPASS_EN.
module tb_param_register_file;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs, rt, write_reg;
    logic        rd_en, RegWrite, init_req;
    logic [31:0] write_data;
    logic [31:0] a, b;
    logic        rd_valid, ready;

    int vectors = 0;
    int errors  = 0;

    param_register_file #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(8), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt), .rd_en(rd_en),
        .write_reg(write_reg), .RegWrite(RegWrite), .write_data(write_data),
        .init_req(init_req), .a(a), .b(b), .rd_valid(rd_valid), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = 1'b0; RegWrite = 1'b0; init_req = 1'b0;
    endtask

    task automatic test_reset();
        int cnt;
        reset = 1'b0; rs = '0; rt = '0; write_reg = '0; write_data = '0;
        idle();
        tick(); tick();
        vectors++; if (a !== 32'h0) begin errors++; $display("FAIL reset_a got %h want 0", a); end
        vectors++; if (b !== 32'h0) begin errors++; $display("FAIL reset_b got %h want 0", b); end
        vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
        reset = 1'b1;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 20) begin tick(); cnt++; end
        vectors++; if (cnt != 8) begin errors++; $display("FAIL reset_init_len got %0d want 8", cnt); end
    endtask

    task automatic test_init_zero();
        for (int i = 0; i < 8; i += 2) begin
            rs = 5'(i); rt = 5'(i + 1); rd_en = 1'b1;
            tick();
            vectors++; if (a !== 32'h0 || b !== 32'h0 || rd_valid !== 1'b1) begin
                errors++; $display("FAIL init_zero r%0d/r%0d got a=%h b=%h v=%b want 0 0 1", i, i + 1, a, b, rd_valid);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_write_read();
        RegWrite = 1'b1; write_reg = 5'd3; write_data = 32'h0000_0005;
        tick();
        write_reg = 5'd4; write_data = 32'hA5A5_5A5A;
        tick();
        write_reg = 5'd7; write_data = 32'h1234_5678;
        tick();
        RegWrite = 1'b0; rd_en = 1'b1; rs = 5'd3; rt = 5'd3;
        tick();
        vectors++; if (a !== 32'h5 || b !== 32'h5 || rd_valid !== 1'b1) begin
            errors++; $display("FAIL rd_r3_r3 got a=%h b=%h v=%b want 5 5 1", a, b, rd_valid);
        end
        rs = 5'd4; rt = 5'd7;
        tick();
        vectors++; if (a !== 32'hA5A5_5A5A || b !== 32'h1234_5678) begin
            errors++; $display("FAIL rd_r4_r7 got a=%h b=%h want a5a55a5a 12345678", a, b);
        end
        rd_en = 1'b0; rs = 5'd3; rt = 5'd3;
        tick();
        vectors++; if (rd_valid !== 1'b0 || a !== 32'hA5A5_5A5A || b !== 32'h1234_5678) begin
            errors++; $display("FAIL rd_hold got a=%h b=%h v=%b want a5a55a5a 12345678 0", a, b, rd_valid);
        end
    endtask

    task automatic test_collision();
        logic [31:0] exp_a;
`ifdef REGFILE_BYPASS_EN
        exp_a = 32'hDEAD_BEEF;
`else
        exp_a = 32'h0;
`endif
        RegWrite = 1'b1; write_reg = 5'd2; write_data = 32'hDEAD_BEEF;
        rd_en = 1'b1; rs = 5'd2; rt = 5'd3;
        tick();
        vectors++; if (a !== exp_a || b !== 32'h5) begin
            errors++; $display("FAIL collision got a=%h b=%h want %h 5", a, b, exp_a);
        end
        RegWrite = 1'b0; rs = 5'd2; rt = 5'd2;
        tick();
        vectors++; if (a !== 32'hDEAD_BEEF || b !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL after_collision got a=%h b=%h want deadbeef", a, b);
        end
        idle();
    endtask

    task automatic test_zero_reg();
        RegWrite = 1'b1; write_reg = 5'd0; write_data = 32'hFFFF_FFFF;
        tick();
        RegWrite = 1'b0; rd_en = 1'b1; rs = 5'd0; rt = 5'd9;
        tick();
        vectors++; if (a !== 32'h0 || b !== 32'h0) begin
            errors++; $display("FAIL zero_reg_rd got a=%h b=%h want 0 0", a, b);
        end
        RegWrite = 1'b1; write_reg = 5'd0; write_data = 32'hFFFF_FFFF; rs = 5'd0; rt = 5'd0;
        tick();
        vectors++; if (a !== 32'h0 || b !== 32'h0) begin
            errors++; $display("FAIL zero_reg_bypass got a=%h b=%h want 0 0", a, b);
        end
        write_reg = 5'd9; write_data = 32'h0000_0099; rd_en = 1'b0;
        tick();
        RegWrite = 1'b0; rd_en = 1'b1; rs = 5'd1; rt = 5'd9;
        tick();
        vectors++; if (a !== 32'h0 || b !== 32'h0) begin
            errors++; $display("FAIL out_of_range got a=%h b=%h want 0 0", a, b);
        end
        idle();
    endtask

    task automatic test_init_req();
        int cnt;
        RegWrite = 1'b1; write_reg = 5'd1; write_data = 32'h0000_0011; init_req = 1'b1;
        tick();
        vectors++; if (ready !== 1'b0) begin errors++; $display("FAIL init_req_ready got %b want 0", ready); end
        // Keep poking during INIT: nothing should restart or land.
        write_reg = 5'd2; write_data = 32'h0000_0077; rd_en = 1'b1; rs = 5'd2; rt = 5'd3;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 20) begin
            tick(); cnt++;
            vectors++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL init_rd_valid got %b want 0", rd_valid); end
        end
        idle();
        vectors++; if (cnt != 8) begin errors++; $display("FAIL init_req_len got %0d want 8", cnt); end
        rd_en = 1'b1; rs = 5'd1; rt = 5'd2;
        tick();
        vectors++; if (a !== 32'h0 || b !== 32'h0 || rd_valid !== 1'b1) begin
            errors++; $display("FAIL init_req_lost got a=%h b=%h v=%b want 0 0 1", a, b, rd_valid);
        end
        rs = 5'd3; rt = 5'd4;
        tick();
        vectors++; if (a !== 32'h0 || b !== 32'h0) begin
            errors++; $display("FAIL init_req_cleared got a=%h b=%h want 0 0", a, b);
        end
        idle();
    endtask

    task automatic test_reset_mid_read();
        int cnt;
        RegWrite = 1'b1; write_reg = 5'd5; write_data = 32'h0000_0055;
        tick();
        RegWrite = 1'b0; rd_en = 1'b1; rs = 5'd5; rt = 5'd5;
        tick();
        vectors++; if (a !== 32'h55 || b !== 32'h55 || rd_valid !== 1'b1) begin
            errors++; $display("FAIL pre_reset_rd got a=%h b=%h v=%b want 55 55 1", a, b, rd_valid);
        end
        #2 reset = 1'b0;
        #1;
        vectors++; if (a !== 32'h0 || b !== 32'h0 || rd_valid !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL async_reset got a=%h b=%h v=%b r=%b want 0 0 0 0", a, b, rd_valid, ready);
        end
        tick();
        reset = 1'b1;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 20) begin tick(); cnt++; end
        vectors++; if (cnt != 8) begin errors++; $display("FAIL rerun_init_len got %0d want 8", cnt); end
        tick();
        vectors++; if (a !== 32'h0 || rd_valid !== 1'b1) begin
            errors++; $display("FAIL post_reset_rd got a=%h v=%b want 0 1", a, rd_valid);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_init_zero();
        test_write_read();
        test_collision();
        test_zero_reg();
        test_init_req();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
